stim_train_ctrl: RTL and testbench
==================================

Name: stim_train_ctrl

Overview:
- Upstream controller for the stimulation output stage.
- Generates a gated stimulation window, stim_en. The stim stage uses stim_en as its enable/reset input and chops it into the carrier pulse train.
- On a start request it produces a configurable burst of N on-windows: pulse_width cycles on, repeating every period cycles.
- Supports abort, busy/done status and a pulse counter for the host interface.

Parameters:
CNT_W, 16, width of pulse_width and period timing fields (cycles)
NP_W, 8, width of n_pulses and pulse_cnt

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  burst request, sampled only in IDLE
abort  input  1  terminate burst immediately
pulse_width  input  CNT_W  on-window length in cycles, latched at start
period  input  CNT_W  pulse repetition period in cycles, latched at start
n_pulses  input  NP_W  pulses per burst, latched at start
stim_en  output  1  gate to the stimulation stage, registered
busy  output  1  high while a burst is in progress (ON/OFF states)
done  output  1  one-cycle pulse on normal burst completion
pulse_cnt  output  NP_W  pulses started in the current/last burst

Behaviour:
- Reset: rst=1 at a rising edge forces state IDLE and clears stim_en, busy, done, pulse_cnt and all internal counters. It overrides every other input, including mid-burst.
- States: IDLE, ON, OFF, DONE. All outputs are registered.
- IDLE:
  - start=1 and abort=0 latches pulse_width, period and n_pulses and clears pulse_cnt.
  - If latched pulse_width==0 or n_pulses==0: go to DONE; no stim_en.
  - Otherwise: go to ON; stim_en=1, busy=1, pulse_cnt=1 from the next cycle.
- Latency: start sampled at edge t gives stim_en high in cycle t+1.
- ON: stim_en high for exactly pw cycles (pw = latched pulse_width). At the end of the on-window:
  - if pulse_cnt==n_pulses, go to DONE;
  - else go to OFF.
- OFF: stim_en low for off = max(period − pw, 1) cycles. A period ≤ pw is clamped to a 1-cycle gap, so the effective period is pw+1. Then go to ON and increment pulse_cnt.
- DONE: lasts exactly one cycle with done=1, busy=0, stim_en=0; then IDLE. start is ignored in DONE.
- pulse_cnt holds its value after DONE/abort until the next accepted start. No wrap is possible because pulse_cnt ≤ n_pulses.
- start while busy (ON/OFF/DONE) is ignored. Inputs changing mid-burst have no effect, because the configuration is latched.
- abort=1 in ON or OFF:
  - next cycle: IDLE, stim_en=0, busy=0, done stays 0;
  - a truncated on-window is permitted.
- abort in IDLE blocks a simultaneous start. abort in DONE has no effect; done still pulses.
- Cycle counters are CNT_W bits wide, count down from the loaded value and never wrap.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> stim_en=busy=done=0, pulse_cnt=0 throughout.
- Nominal burst: pw=3, period=5, n=2, start at cycle 10:
  - stim_en high cycles 11–13, low 14–15, high 16–18;
  - done=1 only in cycle 19; busy high 11–18;
  - pulse_cnt=1 at 11, 2 at 16, holds 2 afterward.
- Clamp and zero cases:
  - pw=4, period=2, n=3 -> on 4 cycles / off 1 cycle ×3, done after the 3rd on-window;
  - pw=0 or n=0 -> no stim_en, done one cycle after start, busy never high.
- Abort mid-pulse: pw=10, period=20, n=5, abort in the 4th on-cycle of pulse 2 -> stim_en low next cycle, busy low, done never asserted, pulse_cnt holds 2.
- Start during busy and start+abort together:
  - a second start in the OFF phase is ignored, so the burst length is unchanged;
  - start=abort=1 in IDLE -> remains IDLE.
- Reset mid-burst: rst=1 during ON of pulse 3 -> next cycle all outputs 0, pulse_cnt=0; a new start then behaves as in the nominal burst.

Source files
------------

// File: rtl/stim_train_ctrl.sv
// Stimulation window controller: produces a burst of n_pulses on-windows of
// pulse_width cycles, repeating every period cycles, with abort and status.
module stim_train_ctrl #(
  parameter int CNT_W = 16,
  parameter int NP_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] period,
  input  logic [NP_W-1:0]  n_pulses,
  output logic             stim_en,
  output logic             busy,
  output logic             done,
  output logic [NP_W-1:0]  pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] pw_q, pw_n;
  logic [CNT_W-1:0] per_q, per_n;
  logic [NP_W-1:0]  np_q, np_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [NP_W-1:0]  pcnt_n;
  logic [CNT_W-1:0] off_len;

  // A period not longer than the on-window still leaves a one-cycle gap.
  assign off_len = (per_q > pw_q) ? (per_q - pw_q) : CNT_W'(1);

  always_comb begin
    state_n = state;
    pw_n    = pw_q;
    per_n   = per_q;
    np_n    = np_q;
    cnt_n   = cnt_q;
    pcnt_n  = pulse_cnt;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          pw_n   = pulse_width;
          per_n  = period;
          np_n   = n_pulses;
          pcnt_n = '0;
          if (pulse_width == '0 || n_pulses == '0) begin
            state_n = DONE;
          end else begin
            state_n = ON;
            cnt_n   = pulse_width;
            pcnt_n  = NP_W'(1);
          end
        end
      end
      ON: begin
        // cnt_q holds the on-cycles remaining including the current one.
        if (abort) begin
          state_n = IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          if (pulse_cnt == np_q) begin
            state_n = DONE;
          end else begin
            state_n = OFF;
            cnt_n   = off_len;
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      OFF: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_n = ON;
          cnt_n   = pw_q;
          pcnt_n  = pulse_cnt + NP_W'(1);
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pw_q      <= '0;
      per_q     <= '0;
      np_q      <= '0;
      cnt_q     <= '0;
      pulse_cnt <= '0;
      stim_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      pw_q      <= pw_n;
      per_q     <= per_n;
      np_q      <= np_n;
      cnt_q     <= cnt_n;
      pulse_cnt <= pcnt_n;
      stim_en   <= (state_n == ON);
      busy      <= (state_n == ON) || (state_n == OFF);
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_stim_train_ctrl.sv
// Scoreboard bench for stim_train_ctrl: an arithmetic burst model pushes the
// expected outputs per clock, a negedge monitor pops and compares them.
module tb_stim_train_ctrl;

  localparam int CNT_W = 16;
  localparam int NP_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] pulse_width;
  logic [CNT_W-1:0] period;
  logic [NP_W-1:0]  n_pulses;
  logic             stim_en;
  logic             busy;
  logic             done;
  logic [NP_W-1:0]  pulse_cnt;

  always #5 clk = ~clk;

  stim_train_ctrl #(.CNT_W(CNT_W), .NP_W(NP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .pulse_width (pulse_width),
    .period      (period),
    .n_pulses    (n_pulses),
    .stim_en     (stim_en),
    .busy        (busy),
    .done        (done),
    .pulse_cnt   (pulse_cnt)
  );

  typedef struct {
    int stim;
    int busy;
    int done;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Burst model: a burst accepted at edge es is described by k = edge - es,
  // the effective period P = pw + max(period - pw, 1), and the cycle endk
  // (n*P - off) at which done pulses.
  bit m_active = 1'b0;
  int m_es = 0, m_pw = 0, m_per = 0, m_n = 0, m_hold = 0, edge_no = 0;

  function automatic exp_t outAt(int k, int P, int endk);
    exp_t e;
    e = '{0, 0, 0, 0};
    if (k < endk) begin
      e.stim = ((k % P) < m_pw) ? 1 : 0;
      e.busy = 1;
      e.cnt  = k / P + 1;
    end else begin
      e.done = 1;
      e.cnt  = (endk == 0) ? 0 : m_n;
    end
    return e;
  endfunction

  task automatic modelEdge(output exp_t e);
    int off, P, endk, kp;
    e = '{0, 0, 0, 0};
    edge_no++;
    if (rst) begin
      m_active = 1'b0;
      m_hold   = 0;
      return;
    end
    off  = (m_per > m_pw) ? (m_per - m_pw) : 1;
    P    = m_pw + off;
    endk = (m_pw == 0 || m_n == 0) ? 0 : m_n * P - off;
    kp   = edge_no - 1 - m_es;
    if (m_active && kp < endk && abort) begin
      m_active = 1'b0;
      m_hold   = kp / P + 1;
    end else if (m_active && kp <= endk) begin
      if (kp + 1 > endk) begin
        m_active = 1'b0;
        m_hold   = (endk == 0) ? 0 : m_n;
      end else begin
        e = outAt(kp + 1, P, endk);
      end
    end else begin
      m_active = 1'b0;
      if (start && !abort) begin
        m_active = 1'b1;
        m_es  = edge_no;
        m_pw  = int'(pulse_width);
        m_per = int'(period);
        m_n   = int'(n_pulses);
        off   = (m_per > m_pw) ? (m_per - m_pw) : 1;
        P     = m_pw + off;
        endk  = (m_pw == 0 || m_n == 0) ? 0 : m_n * P - off;
        e     = outAt(0, P, endk);
      end
    end
    if (!m_active) e.cnt = m_hold;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; the model sees the same inputs the DUT samples.
  task automatic applyStimulus(input logic s, input logic a, input logic r,
                               input int pw, input int per, input int n);
    exp_t e;
    start       = s;
    abort       = a;
    rst         = r;
    pulse_width = CNT_W'(pw);
    period      = CNT_W'(per);
    n_pulses    = NP_W'(n);
    @(posedge clk);
    modelEdge(e);
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 12),
                    $urandom_range(0, 5));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("stim_en", int'(stim_en), e.stim);
      checkOutput("busy", int'(busy), e.busy);
      checkOutput("done", int'(done), e.done);
      checkOutput("pulse_cnt", int'(pulse_cnt), e.cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    start = 1'b0; abort = 1'b0; rst = 1'b1;
    pulse_width = '0; period = '0; n_pulses = '0;

    applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(7);

    // nominal burst, then again with a second start landing in OFF
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 5, 2);
    idle(12);
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 5, 2);
    idle(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 6, 9, 4);
    idle(10);

    // clamped period and zero-length cases
    applyStimulus(1'b1, 1'b0, 1'b0, 4, 2, 3);
    idle(20);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 5, 3);
    idle(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 5, 0);
    idle(3);

    // abort in the 4th on-cycle of pulse 2
    applyStimulus(1'b1, 1'b0, 1'b0, 10, 20, 5);
    idle(23);
    applyStimulus(1'b0, 1'b1, 1'b0, 10, 20, 5);
    idle(5);

    // start and abort together in IDLE
    applyStimulus(1'b1, 1'b1, 1'b0, 3, 5, 2);
    idle(3);

    // abort during DONE does not suppress done
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 1, 1);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, 1, 1);
    idle(3);

    // reset during ON of pulse 3, then a fresh nominal burst
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 5, 5);
    idle(11);
    applyStimulus(1'b0, 1'b0, 1'b1, 3, 5, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 5, 2);
    idle(15);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 299) == 0), $urandom_range(0, 6),
                    $urandom_range(0, 10), $urandom_range(0, 4));
    end

    idle(2);
    @(negedge clk);
    #1;
    checkOutput("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
